// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery multiplier family.
//   state_t   : controller states and their 2-bit encoding
//   cnt_width : width of an iteration counter able to hold 0..width
package mont_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOOP = 2'd1,
        SUB  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mont_step.sv
// One radix-2 Montgomery iteration, purely combinational.
//   t      in  WIDTH+2  running accumulator (t < 2m)
//   a_bit  in  1        current multiplicand bit
//   b      in  WIDTH    multiplier
//   m      in  WIDTH    odd modulus
//   t_next out WIDTH+2  (t + a_bit*b + q*m) / 2, q chosen so the sum is even
module mont_step #(
    parameter int WIDTH = 512
) (
    input  logic [WIDTH+1:0] t,
    input  logic             a_bit,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH+1:0] t_next
);

    logic [WIDTH+1:0] u;

    assign u = t + (a_bit ? {2'b00, b} : '0);

    // Adding the odd modulus clears bit 0, so the shift is an exact halving.
    // The sum stays below 4m, which fits in WIDTH+2 bits.
    assign t_next = (u + (u[0] ? {2'b00, m} : '0)) >> 1;

endmodule

// File: rtl/montgomery_param.sv
// Parametrised radix-2 Montgomery modular multiplier:
//   result = in_a * in_b * 2^-WIDTH mod in_m   (in_m odd, in_a/in_b < in_m)
// Ports:
//   clk     in  1      rising-edge clock
//   resetn  in  1      asynchronous active-low reset
//   start   in  1      request pulse, accepted in IDLE or DONE
//   in_a    in  WIDTH  multiplicand, sampled with start
//   in_b    in  WIDTH  multiplier, sampled with start
//   in_m    in  WIDTH  modulus, sampled with start
//   result  out WIDTH  product, held until the next operation writes it
//   done    out 1      one-cycle pulse, result valid
//   busy    out 1      high while iterating or reducing
//   err     out 1      with done: the modulus was even and was rejected
module montgomery_param
    import mont_pkg::*;
#(
    parameter int WIDTH = 512,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             err
);

    state_t           state;
    logic [WIDTH-1:0] a_sh;     // multiplicand, shifted right so bit 0 is a[i]
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] m_r;
    logic [WIDTH+1:0] t_r;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic [WIDTH+1:0] t_next;
    logic [WIDTH+1:0] diff;
    logic [WIDTH+1:0] t_red;

    assign accept = start && ((state == IDLE) || (state == DONE));

    mont_step #(.WIDTH(WIDTH)) u_step (
        .t      (t_r),
        .a_bit  (a_sh[0]),
        .b      (b_r),
        .m      (m_r),
        .t_next (t_next)
    );

    // Since t < 2m < 2^(WIDTH+1), the top bit of t - m is set only on borrow.
    assign diff  = t_r - {2'b00, m_r};
    assign t_red = diff[WIDTH+1] ? t_r : diff;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_r    <= '0;
            m_r    <= '0;
            t_r    <= '0;
            cnt    <= '0;
            result <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        a_sh <= in_a;
                        b_r  <= in_b;
                        m_r  <= in_m;
                        t_r  <= '0;
                        cnt  <= '0;
                        if (!in_m[0]) begin
                            // Even modulus has no inverse of 2: reject at once.
                            state  <= DONE;
                            done   <= 1'b1;
                            err    <= 1'b1;
                            result <= '0;
                            busy   <= 1'b0;
                        end else begin
                            state <= LOOP;
                            busy  <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                LOOP: begin
                    t_r  <= t_next;
                    a_sh <= a_sh >> 1;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= SUB;
                    end
                end
                SUB: begin
                    t_r    <= t_red;
                    result <= t_red[WIDTH-1:0];
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/montgomery_param.md
Name: montgomery_param

Overview:
- Parametrised radix-2 Montgomery modular multiplier.
- Computes result = in_a * in_b * 2^-WIDTH mod in_m for odd in_m, with in_a, in_b < in_m.
- Successor to the fixed 512-bit multiplier: generic WIDTH, self-contained datapath with no external adder handshake, busy/err status, result held until the next operation.
- Sits under the RSA exponentiation controller; software/ARM drives it through the same start/done interface.

Parameters:
- WIDTH, 512, operand/modulus width in bits; must be >= 4.
- CNT_W, $clog2(WIDTH+1), width of the iteration counter.

Ports:
- clk  in  1  rising-edge clock.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only when busy=0.
- in_a  in  WIDTH  multiplicand; sampled with start.
- in_b  in  WIDTH  multiplier; sampled with start.
- in_m  in  WIDTH  modulus; sampled with start; must be odd.
- result  out  WIDTH  registered product; valid from done onward, held until the next accepted start.
- done  out  1  one-cycle pulse, result valid.
- busy  out  1  high from the cycle after start is accepted until done.
- err  out  1  registered with done; 1 = even modulus was rejected.

Behaviour:
- Reset (async, resetn=0): state=IDLE; result=0; done=0; busy=0; err=0; counter=0; internal operand/accumulator registers=0. Reset asserted mid-operation aborts immediately; no done is produced.
- States:
  - IDLE: waiting for start.
  - LOOP: one iteration per cycle.
  - SUB: final conditional subtraction.
  - DONE: done pulse; accepts start like IDLE.
- Acceptance: start=1 at an edge in IDLE or DONE latches a, b, m, clears accumulator t (WIDTH+2 bits) and counter i. start while busy=1 is ignored.
- Even modulus: if in_m[0]=0 at acceptance, go directly to DONE. Next cycle: done=1, err=1, result=0; busy never asserts.
- LOOP: per cycle,
  - u = t + (a[i] ? b : 0);
  - if u[0], u = u + m;
  - t = u >> 1; i = i + 1.
  - After iteration i=WIDTH-1, go to SUB.
  - All arithmetic is WIDTH+2 bits wide; the invariant t < 2m holds, so there is no overflow.
- SUB: d = t - m (WIDTH+2 bits). result <= borrow ? t[WIDTH-1:0] : d[WIDTH-1:0]. Go to DONE.
- DONE: done=1, err=0, busy=0 for exactly one cycle, then IDLE unless start is accepted in that same cycle. A start accepted in DONE re-enters LOOP next cycle (back-to-back). result keeps the old value until the new SUB writes it.
- Latency: accept edge E; LOOP occupies edges E+1..E+WIDTH; SUB at edge E+WIDTH+1; done high in the cycle after edge E+WIDTH+1. The total is WIDTH+2 cycles from start to done. Throughput is one operation per WIDTH+2 cycles.
- busy=1 exactly in LOOP and SUB.
- Inputs outside range (a or b >= m, m odd): the block completes with unspecified result, err=0. This is not checked.
- Output is always fully reduced: 0 <= result < m.

Decomposition:
- Package mont_pkg:
  - state enum (IDLE, LOOP, SUB, DONE) and its 2-bit encoding;
  - function computing CNT_W.
- Sub-module mont_step: purely combinational single iteration, (t, a_bit, b, m) -> t_next, WIDTH+2 bits. It is reused by future multi-step unrolled variants.
- Top holds the FSM, counter, operand registers and final subtraction.

Test Plan:
- WIDTH=8, in_m=239, in_a=5, in_b=7 -> done exactly 10 cycles after start, result=227, err=0.
- WIDTH=8, in_m=239, in_a=17 (R mod m), in_b=100 -> result=100. Then in_a=238, in_b=238 -> result=225. Then in_a=0, in_b=200 -> result=0.
- WIDTH=8, in_m=238 (even) -> done the cycle after start, err=1, result=0, busy stays 0.
- start re-pulsed with different operands while busy -> ignored; the first result (227) is unchanged, and exactly one done is produced.
- start asserted in the DONE cycle (5*7, then 1*1, m=239) -> second operation begins immediately; done pulses 10 cycles apart, results 227 then 225.
- resetn pulled low at cycle 4 of an operation -> busy, done, result drop to 0 asynchronously. A subsequent start with 5*7 mod 239 -> result 227 with normal latency.
- WIDTH=512 random odd m, a, b < m: compare against a reference model; at least 1000 vectors, all results < m.
